// File: rtl/falafel_pkg.sv
// Shared types for the free-list allocator core and its header LSU.
package falafel_pkg;

  localparam int HW = 32;

  typedef enum logic {
    OP_ALLOC = 1'b0,
    OP_FREE  = 1'b1
  } alloc_op_e;

  typedef enum logic [2:0] {
    LSU_LOCK   = 3'd0,
    LSU_UNLOCK = 3'd1,
    LSU_LOAD   = 3'd2,
    LSU_INSERT = 3'd3,
    LSU_DELETE = 3'd4
  } req_lsu_op_e;

  typedef struct packed {
    logic [HW-1:0] addr;
    logic [HW-1:0] size;
    logic [HW-1:0] next_addr;
  } header_data_t;

  typedef struct packed {
    header_data_t header_data;
    req_lsu_op_e  lsu_op;
    logic         val;
  } header_data_req_t;

  typedef struct packed {
    header_data_t header_data;
    logic         val;
  } header_data_rsp_t;

  // S_IDLE is the all-zero encoding so a cleared register file means idle.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOCK     = 4'd1,
    S_LOAD     = 4'd2,
    S_CMP      = 4'd3,
    S_SPLIT    = 4'd4,
    S_LINK     = 4'd5,
    S_FREE_INS = 4'd6,
    S_UNLOCK   = 4'd7,
    S_WAIT     = 4'd8,
    S_RESP     = 4'd9
  } alloc_state_e;

endpackage

// File: rtl/falafel_alloc_core.sv
// Free-list allocator: walks a linked list of headers through an LSU,
// picks a block (first-fit or best-fit), optionally splits it, and relinks.
module falafel_alloc_core
  import falafel_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int HEADER_SIZE = 16,
  parameter int HEAD_ADDR   = 'h10,
  parameter int ALIGN_LOG2  = 3,
  parameter int MIN_SPLIT   = 8,
  parameter int FIT_MODE    = 0,
  parameter int MAX_HOPS    = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  alloc_op_e        req_op_i,
  input  logic [DATA_W-1:0] req_size_i,
  input  logic [DATA_W-1:0] req_addr_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DATA_W-1:0] rsp_addr_o,
  output logic             rsp_err_o,
  output header_data_req_t req_to_lsu_o,
  input  logic             lsu_ready_i,
  input  header_data_rsp_t rsp_from_lsu_i
);

  localparam logic [DATA_W-1:0] HS       = DATA_W'(HEADER_SIZE);
  localparam logic [DATA_W-1:0] ALIGN_M  = DATA_W'((1 << ALIGN_LOG2) - 1);
  localparam logic [DATA_W-1:0] SPLIT_TH = DATA_W'(HEADER_SIZE + MIN_SPLIT);
  localparam logic [DATA_W-1:0] HEAD     = DATA_W'(HEAD_ADDR);
  localparam logic [DATA_W-1:0] FREE_MIN = DATA_W'(HEAD_ADDR + 2 * HEADER_SIZE);
  localparam int                HOP_W    = $clog2(MAX_HOPS + 1);

  // Whole register file in one struct so a single async-reset process owns it.
  typedef struct packed {
    alloc_state_e      state;
    alloc_state_e      ret;       // issuing state, resumes after LSU response
    alloc_op_e         op;
    logic [DATA_W-1:0] need;
    logic [DATA_W-1:0] curr;
    logic [DATA_W-1:0] link;      // header addr for INSERT / new next for DELETE
    logic [DATA_W-1:0] rsp_addr;
    header_data_t      ld;        // last loaded header
    header_data_t      prev;      // header loaded before ld
    header_data_t      sel;
    header_data_t      sel_prev;
    logic              have;
    logic              rsp_err;
    logic [HOP_W-1:0]  hops;
  } core_regs_t;

  core_regs_t       r_q, w_d;
  header_data_req_t w_lsu;

  // Command size rounding; carry out of the add is an overflow error.
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_need;
  logic              w_bad_cmd;
  assign w_sum     = {1'b0, req_size_i} + {1'b0, ALIGN_M};
  assign w_need    = w_sum[DATA_W-1:0] & ~ALIGN_M;
  assign w_bad_cmd = w_sum[DATA_W] || (w_need == '0) ||
                     ((req_op_i == OP_FREE) && (req_addr_i < FREE_MIN));

  // Candidate evaluation on the header just loaded.
  logic              w_fit, w_better, w_last, w_done, w_c_have, w_split;
  header_data_t      w_c_sel, w_c_prev;
  logic [DATA_W-1:0] w_rem;
  assign w_fit    = (r_q.ld.size != '0) && (r_q.ld.size >= r_q.need);
  assign w_better = w_fit && (!r_q.have || (r_q.ld.size < r_q.sel.size));
  assign w_last   = (r_q.ld.next_addr == '0) || (r_q.hops >= HOP_W'(MAX_HOPS));
  assign w_done   = w_last || ((FIT_MODE == 0) && w_fit);
  assign w_c_have = r_q.have || w_fit;
  assign w_c_sel  = w_better ? r_q.ld   : r_q.sel;
  assign w_c_prev = w_better ? r_q.prev : r_q.sel_prev;
  assign w_rem    = w_c_sel.size - r_q.need;
  assign w_split  = (w_rem >= SPLIT_TH);

  // Next-state, register updates and LSU request drive.
  always_comb begin
    w_d   = r_q;
    w_lsu = '0;
    unique case (r_q.state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_d      = '0;
          w_d.op   = req_op_i;
          w_d.need = w_need;
          if (w_bad_cmd) begin
            w_d.rsp_err = 1'b1;
            w_d.state   = S_RESP;
          end else begin
            w_d.link  = req_addr_i - HS;
            w_d.state = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        w_lsu.lsu_op = LSU_LOCK;
        w_lsu.val    = 1'b1;
      end
      S_LOAD: begin
        w_lsu.lsu_op           = LSU_LOAD;
        w_lsu.header_data.addr = r_q.curr;
        w_lsu.val              = 1'b1;
      end
      S_CMP: begin
        if (!w_done) begin
          w_d.have     = w_c_have;
          w_d.sel      = w_c_sel;
          w_d.sel_prev = w_c_prev;
          w_d.prev     = r_q.ld;
          w_d.curr     = r_q.ld.next_addr;
          w_d.state    = S_LOAD;
        end else if (!w_c_have) begin
          w_d.rsp_err  = 1'b1;
          w_d.rsp_addr = '0;
          w_d.state    = S_UNLOCK;
        end else begin
          w_d.have     = 1'b1;
          w_d.sel      = w_c_sel;
          w_d.sel_prev = w_c_prev;
          w_d.link     = w_split ? (w_c_sel.addr + HS + r_q.need) : w_c_sel.next_addr;
          w_d.rsp_addr = w_c_sel.addr + HS;
          w_d.state    = w_split ? S_SPLIT : S_LINK;
        end
      end
      S_SPLIT: begin
        w_lsu.lsu_op      = LSU_INSERT;
        w_lsu.header_data = '{addr: r_q.link, size: r_q.sel.size - r_q.need - HS,
                              next_addr: r_q.sel.next_addr};
        w_lsu.val         = 1'b1;
      end
      S_FREE_INS: begin
        w_lsu.lsu_op      = LSU_INSERT;
        w_lsu.header_data = '{addr: r_q.link, size: r_q.need, next_addr: r_q.ld.next_addr};
        w_lsu.val         = 1'b1;
      end
      S_LINK: begin
        w_lsu.lsu_op      = LSU_DELETE;
        w_lsu.header_data = '{addr: r_q.sel_prev.addr, size: r_q.sel_prev.size,
                              next_addr: r_q.link};
        w_lsu.val         = 1'b1;
      end
      S_UNLOCK: begin
        w_lsu.lsu_op = LSU_UNLOCK;
        w_lsu.val    = 1'b1;
      end
      S_WAIT: begin
        if (rsp_from_lsu_i.val) begin
          case (r_q.ret)
            S_LOCK: begin
              w_d.curr  = HEAD;
              w_d.state = S_LOAD;
            end
            S_LOAD: begin
              w_d.ld   = rsp_from_lsu_i.header_data;
              w_d.hops = r_q.hops + HOP_W'(1);
              if (r_q.op == OP_FREE) begin
                w_d.sel_prev = rsp_from_lsu_i.header_data;
                w_d.state    = S_FREE_INS;
              end else begin
                w_d.state = S_CMP;
              end
            end
            S_SPLIT, S_FREE_INS: w_d.state = S_LINK;
            S_LINK:              w_d.state = S_UNLOCK;
            S_UNLOCK:            w_d.state = S_RESP;
            default:             w_d.state = S_IDLE;
          endcase
        end
      end
      S_RESP: begin
        if (rsp_ready_i) w_d.state = S_IDLE;
      end
      default: w_d.state = S_IDLE;
    endcase
    if (w_lsu.val && lsu_ready_i) begin
      w_d.ret   = r_q.state;
      w_d.state = S_WAIT;
    end
  end

  // State register; async reset clears everything to idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_q <= '0;
    else         r_q <= w_d;
  end

  assign req_ready_o  = (r_q.state == S_IDLE);
  assign rsp_valid_o  = (r_q.state == S_RESP);
  assign rsp_addr_o   = r_q.rsp_addr;
  assign rsp_err_o    = r_q.rsp_err;
  assign req_to_lsu_o = w_lsu;

endmodule

// File: doc/falafel_alloc_core.md
FALAFEL_ALLOC_CORE -- requirements
Module: falafel_alloc_core

Interface
REQ-001 Params SHALL be: DATA_W = 32, header/addr/size width; HEADER_SIZE = 16, bytes per free-list header; HEAD_ADDR = 'h10, sentinel header address; ALIGN_LOG2 = 3, size alignment; MIN_SPLIT = 8, min split-remainder payload; FIT_MODE = 0, 0 first-fit / 1 best-fit; MAX_HOPS = 1024, traversal limit.
REQ-002 clk_i  in  1  clock.
REQ-003 rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 req_valid_i  in  1  requester command valid.
REQ-005 req_ready_o  out  1  core accepts command (high only in IDLE).
REQ-006 req_op_i  in  alloc_op_e  ALLOC or FREE.
REQ-007 req_size_i  in  DATA_W  payload bytes.
REQ-008 req_addr_i  in  DATA_W  payload address to free (FREE only).
REQ-009 rsp_valid_o  out  1  result valid, held until rsp_ready_i.
REQ-010 rsp_ready_i  in  1  requester takes result.
REQ-011 rsp_addr_o  out  DATA_W  allocated payload address (0 on error/FREE).
REQ-012 rsp_err_o  out  1  command failed.
REQ-013 req_to_lsu_o  out  header_data_req_t  {header_data, lsu_op, val} to LSU.
REQ-014 lsu_ready_i  in  1  LSU accepts request this cycle.
REQ-015 rsp_from_lsu_i  in  header_data_rsp_t  {header_data, val}, val one-cycle pulse.

Function
REQ-016 Command accepted when req_valid_i && req_ready_o; size latched as need = round-up of req_size_i to 2^ALIGN_LOG2.
REQ-017 need == 0 or rounding overflow SHALL go directly to RESP with err=1, no LSU traffic.
REQ-018 LSU request val held with stable fields until lsu_ready_i high same cycle; then WAIT until rsp_from_lsu_i.val.
REQ-019 States: IDLE, LOCK, LOAD, CMP, SPLIT, LINK, FREE_INS, UNLOCK, WAIT, RESP; every command brackets LSU traffic with LOCK ... UNLOCK.
REQ-020 ALLOC: after LOCK, curr = HEAD_ADDR; LOAD curr; CMP on loaded {addr,size,next_addr}; sentinel (size 0) never selected.
REQ-021 First-fit: first header with size >= need selected; prev = previously loaded header.
REQ-022 Best-fit: whole list traversed; candidate replaced only when size >= need and size < best size (ties keep earliest); best and its prev registered.
REQ-023 Traversal ends when next_addr == 0 or MAX_HOPS loads done; no candidate -> UNLOCK then RESP err=1, no INSERT/DELETE issued.
REQ-024 Split when size - need >= HEADER_SIZE + MIN_SPLIT: INSERT {addr=sel.addr+HEADER_SIZE+need, size=sel.size-need-HEADER_SIZE, next=sel.next}, then LINK.
REQ-025 No split: LINK only, prev.next_addr = sel.next_addr.
REQ-026 LINK SHALL issue DELETE with header {addr=prev.addr, next_addr=new link}; then UNLOCK; rsp_addr_o = sel.addr + HEADER_SIZE.
REQ-027 FREE: LOCK; LOAD HEAD_ADDR; FREE_INS INSERT {addr=req_addr-HEADER_SIZE, size=need, next=head.next}; LINK head.next = that addr; UNLOCK; RESP err=0.
REQ-028 FREE with req_addr_i < HEAD_ADDR+2*HEADER_SIZE SHALL respond err=1 without LSU traffic.
REQ-029 RESP holds rsp_valid_o until rsp_ready_i, then IDLE; new command acceptable next cycle.
REQ-030 All address arithmetic modulo 2^DATA_W; size compares unsigned.

Reset
REQ-031 Async reset SHALL force IDLE, req_ready_o=1 after release, rsp_valid_o=0, rsp_addr_o=0, rsp_err_o=0, req_to_lsu_o='0, all registers 0 immediately, including mid-traversal; LSU lock is reset by the same rst_ni.

Structure
REQ-032 alloc_op_e, header_data_t, header_data_req_t/rsp_t, req_lsu_op_e (LOCK, UNLOCK, LOAD, INSERT, DELETE) SHALL live in falafel_pkg.
REQ-033 Single module; no sub-module; one next-state comb process, one async-reset register process.

Verification (HEADER_SIZE=16, HEAD_ADDR='h10, ALIGN_LOG2=3)
REQ-034 List 0x10{0,->0x100},0x100{256,->0}; ALLOC 64 -> INSERT {0x150,176,0}, DELETE {0x10,next 0x150}, rsp 0x110 err 0.
REQ-035 Block 0x100 size 72; ALLOC 61 (need 64) -> no INSERT, DELETE {0x10,next 0}, rsp 0x110.
REQ-036 0x100{256}->0x200{96}->0; ALLOC 80 -> FIT_MODE 1 selects 0x200 (rsp 0x210), FIT_MODE 0 selects 0x100 (rsp 0x110).
REQ-037 ALLOC 512 on REQ-034 list -> LOCK, 2 LOADs, UNLOCK, rsp err 1; ALLOC 0 -> err 1, no LSU val.
REQ-038 FREE addr 0x310 size 64 -> INSERT {0x300,64,head.next}, DELETE {0x10,next 0x300}, err 0.
REQ-039 rst_ni low during WAIT with lsu_ready_i stalled -> outputs at reset values same cycle, IDLE after release.
